axis_dac_serial_multi: RTL and testbench
========================================

AXIS_DAC_SERIAL_MULTI -- requirements
Module: axis_dac_serial_multi

Interface
REQ-001 Parameter NCH, default 4: number of DAC channels, 1..8.
REQ-002 Parameter DAC_BITS, default 20: DAC code width, taken from tdata[31 -: DAC_BITS].
REQ-003 Parameter FRAME_BITS, default 24: serial frame length; must be at least DAC_BITS+4.
REQ-004 Parameter SCLK_DIV, default 2: SCLK half-period in a_clk cycles, at least 1.
REQ-005 Parameter SYNC_IDLE, default 3: minimum a_clk cycles dac_sync_n stays high between frames.
REQ-006 a_clk  in  1  single clock for all logic.
REQ-007 a_resetn  in  1  asynchronous active-low reset.
REQ-008 S_AXIS_tdata  in  NCH*32  channel k setpoint in bits [32k+31:32k], signed.
REQ-009 S_AXIS_tvalid  in  NCH  per-channel valid.
REQ-010 S_AXISCFG_tdata  in  32  raw config frame in bits [FRAME_BITS-1:0].
REQ-011 S_AXISCFG_tvalid  in  1  config data valid.
REQ-012 configuration_mode  in  1  1 = config/hold mode, 0 = stream mode.
REQ-013 configuration_axis  in  3  target channel for config frames.
REQ-014 configuration_send  in  1  a rising edge requests one config frame.
REQ-015 dac_sclk  out  1  shared serial clock, idles high.
REQ-016 dac_sync_n  out  NCH  per-channel frame select, active low.
REQ-017 dac_sdin  out  NCH  per-channel serial data, MSB first.
REQ-018 dac_ldac_n  out  1  load-DAC strobe, active low.
REQ-019 ready  out  1  high when idle with no pending work.
REQ-020 frame_count  out  32  frames completed since reset, wraps at 2^32.

Function
REQ-021 The controller SHALL use states IDLE, LOAD, SHIFT, GAP and LDAC, with transitions IDLE->LOAD->SHIFT->GAP->(LDAC)->IDLE.
REQ-022 In stream mode, a channel whose tvalid is high and whose code differs from its last-sent code SHALL set its pending flag and latch the code.
REQ-023 IDLE SHALL go to LOAD on the cycle after any pending flag is set.
REQ-024 A stream frame SHALL be {4'b0001, code, zero pad} per channel.
REQ-025 In a stream frame, every channel SHALL send its latest code simultaneously, and all dac_sync_n bits SHALL fall together.
REQ-026 In config mode, stream tvalid SHALL be ignored and pending flags cleared.
REQ-027 In config mode, a configuration_send rising edge with S_AXISCFG_tvalid=1 SHALL send S_AXISCFG_tdata[FRAME_BITS-1:0] on channel configuration_axis only; other channels' sync_n and sdin stay 1 and 0.
REQ-028 A configuration_axis value of NCH or above SHALL be ignored: no frame is sent and ready stays 1.
REQ-029 In LOAD, for one cycle, selected sync_n SHALL go low and sdin SHALL present the MSB.
REQ-030 In SHIFT, dac_sclk SHALL fall after SCLK_DIV cycles so the DAC samples, then rise after SCLK_DIV more cycles, at which point sdin advances one bit.
REQ-031 The shift pattern of REQ-030 SHALL repeat for FRAME_BITS bits, for 2*SCLK_DIV*FRAME_BITS cycles total.
REQ-032 GAP SHALL hold all sync_n high and sclk high for SYNC_IDLE cycles; frame_count SHALL increment on GAP entry.
REQ-033 Stream data arriving during LOAD, SHIFT or GAP SHALL update the latched code and pending flag; it is sent in the next frame, not the current one, and a newer value overwrites the older pending value.
REQ-034 A configuration_mode change mid-frame SHALL take effect only at IDLE, and the current frame SHALL complete.
REQ-035 ready SHALL be 0 from LOAD entry until return to IDLE with no pending work, and 0 while a send edge is unserviced.
REQ-036 When both a config request and stream pending exist, only the request matching the current mode SHALL be serviced.

Reset
REQ-037 On a_resetn low: state=IDLE, dac_sclk=1, dac_sync_n=all 1, dac_sdin=0, dac_ldac_n=1, ready=1, frame_count=0, pending flags=0, last-sent codes=0.
REQ-038 Reset asserted mid-frame SHALL abort the frame immediately and asynchronously, and the aborted frame SHALL not be counted.
REQ-039 After a_resetn rises, a send edge already high SHALL not be treated as a rising edge.

Configuration
REQ-040 With macro AXIS_DAC_SERIAL_LDAC_EN defined, stream frames SHALL pass through the LDAC state after GAP, driving dac_ldac_n low for SCLK_DIV cycles so all channels update together; config frames SHALL skip LDAC.
REQ-041 Without AXIS_DAC_SERIAL_LDAC_EN, the LDAC state SHALL not exist, dac_ldac_n SHALL be tied to 0 (DAC updates on sync rise), and GAP SHALL return directly to IDLE.

Verification
REQ-042 Reset, stream mode, ch0 tdata=0x00010000 tvalid=1 -> one frame; ch0 sdin shifts 0x100010 (24 bits, defaults); frame lasts 96 cycles; frame_count=1.
REQ-043 Same value resent on ch0 -> no frame; ready stays 1.
REQ-044 Config mode, axis=2, cfg=0x200012, send edge -> only dac_sync_n[2] low; 24 bits 0x200012 on sdin[2]; ready low until GAP ends.
REQ-045 Config mode, axis=5 with NCH=4, send edge -> no sync activity; ready=1.
REQ-046 New ch1 value at bit 10 of an active frame -> current frame unchanged; a second frame carries the new value; frame_count=2.
REQ-047 a_resetn low at bit 12 -> all sync_n=1 and sclk=1 in the same cycle; frame_count=0; with LDAC_EN, no ldac pulse.

Source files
------------

// File: rtl/axis_dac_serial_multi.sv
// -----------------------------------------------------------------------------
// axis_dac_serial_multi
//
// Multi-channel serial DAC front end. Each channel takes a signed setpoint from
// an AXI-Stream slice. A channel that changes its code marks itself pending.
// The controller then shifts one frame per DAC over a shared SCLK. Every
// channel is sent at once, and the sync_n lines fall together. In
// configuration mode, stream data is ignored. A rising edge on
// configuration_send then shifts one raw config frame to a single channel.
//
// Optional feature (macro AXIS_DAC_SERIAL_LDAC_EN):
//   defined   - stream frames end with an LDAC state that pulses dac_ldac_n low
//               for SCLK_DIV cycles; config frames skip it.
//   undefined - no LDAC state, dac_ldac_n tied low (DAC updates on sync rise).
//
// Ports:
//   a_clk, a_resetn     clock, asynchronous active-low reset
//   S_AXIS_tdata/tvalid per-channel setpoints (code = tdata[32k+31 -: DAC_BITS])
//   S_AXISCFG_tdata/tvalid raw config frame in bits [FRAME_BITS-1:0]
//   configuration_mode  1 = config/hold, 0 = stream
//   configuration_axis  target channel for config frames
//   configuration_send  rising edge requests one config frame
//   dac_sclk            shared serial clock, idles high
//   dac_sync_n          per-channel frame select, active low
//   dac_sdin            per-channel serial data, MSB first
//   dac_ldac_n          load-DAC strobe, active low
//   ready               idle with no pending work
//   frame_count         frames completed since reset (wraps)
// -----------------------------------------------------------------------------
module axis_dac_serial_multi #(
   parameter int NCH        = 4,
   parameter int DAC_BITS   = 20,
   parameter int FRAME_BITS = 24,
   parameter int SCLK_DIV   = 2,
   parameter int SYNC_IDLE  = 3
) (
   input  logic                a_clk,
   input  logic                a_resetn,
   input  logic [NCH*32-1:0]   S_AXIS_tdata,
   input  logic [NCH-1:0]      S_AXIS_tvalid,
   input  logic [31:0]         S_AXISCFG_tdata,
   input  logic                S_AXISCFG_tvalid,
   input  logic                configuration_mode,
   input  logic [2:0]          configuration_axis,
   input  logic                configuration_send,
   output logic                dac_sclk,
   output logic [NCH-1:0]      dac_sync_n,
   output logic [NCH-1:0]      dac_sdin,
   output logic                dac_ldac_n,
   output logic                ready,
   output logic [31:0]         frame_count
);

`ifdef AXIS_DAC_SERIAL_LDAC_EN
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_SHIFT = 3'd2,
      ST_GAP   = 3'd3,
      ST_LDAC  = 3'd4
   } state_t;
`else
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_SHIFT = 3'd2,
      ST_GAP   = 3'd3
   } state_t;
`endif

   state_t                state_q, state_d;
   logic                  sclk_q, sclk_d;
   logic [NCH-1:0]        sync_n_q, sync_n_d;
   logic [NCH-1:0]        sdin_q, sdin_d;
   logic [NCH-1:0]        pend_q, pend_d;
   logic                  ready_q, ready_d;
   logic [31:0]           frame_count_q, frame_count_d;
   logic [DAC_BITS-1:0]   code_q [NCH];
   logic [DAC_BITS-1:0]   code_d [NCH];
   logic [DAC_BITS-1:0]   last_q [NCH];
   logic [DAC_BITS-1:0]   last_d [NCH];
   logic [FRAME_BITS-1:0] shreg_q [NCH];
   logic [FRAME_BITS-1:0] shreg_d [NCH];
   logic [15:0]           ph_q, ph_d;
   logic [15:0]           bit_q, bit_d;
   logic [15:0]           cnt_q, cnt_d;
   logic                  send_prev_q, send_prev_d;
   logic                  cfg_req_q, cfg_req_d;
   logic [2:0]            cfg_axis_q, cfg_axis_d;
   logic [FRAME_BITS-1:0] cfg_data_q, cfg_data_d;
   logic                  send_edge_s;
   logic                  axis_ok_s;
`ifdef AXIS_DAC_SERIAL_LDAC_EN
   logic                  is_cfg_q, is_cfg_d;
   logic                  ldac_n_q, ldac_n_d;
`endif

   // Only part of each stream word and of the config word carries frame data
   logic unused_s;
   assign unused_s = ^{S_AXIS_tdata, S_AXISCFG_tdata};

   // Stream frame layout: command nibble 0001, DAC code, zero padding
   function automatic logic [FRAME_BITS-1:0] stream_frame(input logic [DAC_BITS-1:0] code);
      logic [FRAME_BITS-1:0] f;
      f = {FRAME_BITS{1'b0}};
      f[FRAME_BITS-1 -: 4]        = 4'b0001;
      f[FRAME_BITS-5 -: DAC_BITS] = code;
      return f;
   endfunction

   // Next-state, next-output and stream/config capture logic
   always_comb begin
      state_d       = state_q;
      sclk_d        = sclk_q;
      sync_n_d      = sync_n_q;
      sdin_d        = sdin_q;
      pend_d        = pend_q;
      frame_count_d = frame_count_q;
      code_d        = code_q;
      last_d        = last_q;
      shreg_d       = shreg_q;
      ph_d          = ph_q;
      bit_d         = bit_q;
      cnt_d         = cnt_q;
      cfg_req_d     = cfg_req_q;
      cfg_axis_d    = cfg_axis_q;
      cfg_data_d    = cfg_data_q;
`ifdef AXIS_DAC_SERIAL_LDAC_EN
      is_cfg_d      = is_cfg_q;
      ldac_n_d      = ldac_n_q;
`endif
      send_prev_d   = configuration_send;
      send_edge_s   = configuration_send & ~send_prev_q;
      axis_ok_s     = ({1'b0, configuration_axis} < 4'(NCH));

      case (state_q)
         ST_IDLE: begin
            // The mode input is only honoured here, so a frame in flight always completes
            if (configuration_mode && cfg_req_q) begin
               state_d   = ST_LOAD;
               cfg_req_d = 1'b0;
`ifdef AXIS_DAC_SERIAL_LDAC_EN
               is_cfg_d  = 1'b1;
`endif
               for (int k = 0; k < NCH; k++) begin
                  if (cfg_axis_q == 3'(k)) begin
                     shreg_d[k]  = cfg_data_q;
                     sync_n_d[k] = 1'b0;
                  end else begin
                     shreg_d[k]  = {FRAME_BITS{1'b0}};
                     sync_n_d[k] = 1'b1;
                  end
                  sdin_d[k] = shreg_d[k][FRAME_BITS-1];
               end
            end else if (!configuration_mode && (|pend_q)) begin
               state_d  = ST_LOAD;
`ifdef AXIS_DAC_SERIAL_LDAC_EN
               is_cfg_d = 1'b0;
`endif
               // Every channel sends its latest code in the same frame
               for (int k = 0; k < NCH; k++) begin
                  shreg_d[k]  = stream_frame(code_q[k]);
                  sync_n_d[k] = 1'b0;
                  sdin_d[k]   = shreg_d[k][FRAME_BITS-1];
                  last_d[k]   = code_q[k];
                  pend_d[k]   = 1'b0;
               end
            end else if (!configuration_mode) begin
               // A config request can no longer be serviced once back in stream mode
               cfg_req_d = 1'b0;
            end else begin
               cfg_req_d = cfg_req_q;
            end
         end
         ST_LOAD: begin
            state_d = ST_SHIFT;
            ph_d    = 16'd0;
            bit_d   = 16'd0;
            sclk_d  = 1'b1;
         end
         ST_SHIFT: begin
            // Each bit: SCLK_DIV cycles high, SCLK_DIV low; data moves on the rising edge
            if (ph_q == 16'(2*SCLK_DIV-1)) begin
               if (bit_q == 16'(FRAME_BITS-1)) begin
                  state_d       = ST_GAP;
                  cnt_d         = 16'd0;
                  sclk_d        = 1'b1;
                  sync_n_d      = {NCH{1'b1}};
                  sdin_d        = {NCH{1'b0}};
                  frame_count_d = frame_count_q + 32'd1;
               end else begin
                  ph_d   = 16'd0;
                  bit_d  = bit_q + 16'd1;
                  sclk_d = 1'b1;
                  for (int k = 0; k < NCH; k++) begin
                     shreg_d[k] = shreg_q[k] << 1;
                     sdin_d[k]  = shreg_q[k][FRAME_BITS-2];
                  end
               end
            end else begin
               ph_d   = ph_q + 16'd1;
               sclk_d = ((ph_q + 16'd1) < 16'(SCLK_DIV));
            end
         end
         ST_GAP: begin
            if (cnt_q == 16'(SYNC_IDLE-1)) begin
`ifdef AXIS_DAC_SERIAL_LDAC_EN
               if (!is_cfg_q) begin
                  state_d  = ST_LDAC;
                  cnt_d    = 16'd0;
                  ldac_n_d = 1'b0;
               end else begin
                  state_d  = ST_IDLE;
               end
`else
               state_d = ST_IDLE;
`endif
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
`ifdef AXIS_DAC_SERIAL_LDAC_EN
         ST_LDAC: begin
            if (cnt_q == 16'(SCLK_DIV-1)) begin
               state_d  = ST_IDLE;
               ldac_n_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
`endif
         default: begin
            state_d  = ST_IDLE;
            sclk_d   = 1'b1;
            sync_n_d = {NCH{1'b1}};
            sdin_d   = {NCH{1'b0}};
         end
      endcase

      // Stream capture runs in every state; it runs after the load so that
      // data arriving in the load cycle is kept for the next frame
      for (int k = 0; k < NCH; k++) begin
         if (configuration_mode) begin
            pend_d[k] = 1'b0;
         end else if (S_AXIS_tvalid[k]) begin
            code_d[k] = S_AXIS_tdata[32*k+31 -: DAC_BITS];
            pend_d[k] = (S_AXIS_tdata[32*k+31 -: DAC_BITS] != last_d[k]);
         end else begin
            pend_d[k] = pend_d[k];
         end
      end

      // Config request capture; an out-of-range channel is dropped here
      if (send_edge_s && configuration_mode && S_AXISCFG_tvalid && axis_ok_s) begin
         cfg_req_d  = 1'b1;
         cfg_axis_d = configuration_axis;
         cfg_data_d = S_AXISCFG_tdata[FRAME_BITS-1:0];
      end else begin
         cfg_req_d  = cfg_req_d;
      end

      ready_d = (state_d == ST_IDLE) && !(|pend_d) && !cfg_req_d;
   end

   // State and output registers; reset aborts any frame immediately
   always_ff @(posedge a_clk or negedge a_resetn) begin
      if (!a_resetn) begin
         state_q       <= ST_IDLE;
         sclk_q        <= 1'b1;
         sync_n_q      <= {NCH{1'b1}};
         sdin_q        <= {NCH{1'b0}};
         pend_q        <= {NCH{1'b0}};
         ready_q       <= 1'b1;
         frame_count_q <= 32'd0;
         for (int k = 0; k < NCH; k++) begin
            code_q[k]  <= {DAC_BITS{1'b0}};
            last_q[k]  <= {DAC_BITS{1'b0}};
            shreg_q[k] <= {FRAME_BITS{1'b0}};
         end
         ph_q          <= 16'd0;
         bit_q         <= 16'd0;
         cnt_q         <= 16'd0;
         // A send line already high at reset release is not an edge
         send_prev_q   <= 1'b1;
         cfg_req_q     <= 1'b0;
         cfg_axis_q    <= 3'd0;
         cfg_data_q    <= {FRAME_BITS{1'b0}};
`ifdef AXIS_DAC_SERIAL_LDAC_EN
         is_cfg_q      <= 1'b0;
         ldac_n_q      <= 1'b1;
`endif
      end else begin
         state_q       <= state_d;
         sclk_q        <= sclk_d;
         sync_n_q      <= sync_n_d;
         sdin_q        <= sdin_d;
         pend_q        <= pend_d;
         ready_q       <= ready_d;
         frame_count_q <= frame_count_d;
         code_q        <= code_d;
         last_q        <= last_d;
         shreg_q       <= shreg_d;
         ph_q          <= ph_d;
         bit_q         <= bit_d;
         cnt_q         <= cnt_d;
         send_prev_q   <= send_prev_d;
         cfg_req_q     <= cfg_req_d;
         cfg_axis_q    <= cfg_axis_d;
         cfg_data_q    <= cfg_data_d;
`ifdef AXIS_DAC_SERIAL_LDAC_EN
         is_cfg_q      <= is_cfg_d;
         ldac_n_q      <= ldac_n_d;
`endif
      end
   end

   assign dac_sclk    = sclk_q;
   assign dac_sync_n  = sync_n_q;
   assign dac_sdin    = sdin_q;
   assign ready       = ready_q;
   assign frame_count = frame_count_q;
`ifdef AXIS_DAC_SERIAL_LDAC_EN
   assign dac_ldac_n  = ldac_n_q;
`else
   assign dac_ldac_n  = 1'b0;
`endif

endmodule

// File: tb/tb_axis_dac_serial_multi.sv
// Testbench for axis_dac_serial_multi (default parameters).
// Expected frames are queued when stimulus is driven. A monitor decodes the
// serial lines and compares each finished frame with the head of the queue.
module tb_axis_dac_serial_multi;
   localparam int NCH        = 4;
   localparam int DAC_BITS   = 20;
   localparam int FRAME_BITS = 24;
   localparam int SCLK_DIV   = 2;
   localparam int SYNC_IDLE  = 3;
   localparam int FRAME_LOW  = 1 + 2*SCLK_DIV*FRAME_BITS;

   logic                a_clk = 1'b0;
   logic                a_resetn = 1'b1;
   logic [NCH*32-1:0]   S_AXIS_tdata;
   logic [NCH-1:0]      S_AXIS_tvalid;
   logic [31:0]         S_AXISCFG_tdata;
   logic                S_AXISCFG_tvalid;
   logic                configuration_mode;
   logic [2:0]          configuration_axis;
   logic                configuration_send;
   logic                dac_sclk;
   logic [NCH-1:0]      dac_sync_n;
   logic [NCH-1:0]      dac_sdin;
   logic                dac_ldac_n;
   logic                ready;
   logic [31:0]         frame_count;

   int total = 0;
   int bad   = 0;

   logic [NCH-1:0]                 exp_mask_q[$];
   logic [NCH-1:0][FRAME_BITS-1:0] exp_data_q[$];

   int                             frames_seen = 0;
   int                             ldac_low_cnt = 0;
   logic                           mon_active = 1'b0;
   int                             mon_nbits = 0;
   int                             mon_low = 0;
   logic                           mon_shape_err = 1'b0;
   logic                           mon_prev_sclk = 1'b1;
   logic [NCH-1:0]                 mon_mask = '0;
   logic [NCH-1:0][FRAME_BITS-1:0] mon_data = '0;

   axis_dac_serial_multi #(
      .NCH(NCH), .DAC_BITS(DAC_BITS), .FRAME_BITS(FRAME_BITS),
      .SCLK_DIV(SCLK_DIV), .SYNC_IDLE(SYNC_IDLE)
   ) dut (
      .a_clk(a_clk), .a_resetn(a_resetn),
      .S_AXIS_tdata(S_AXIS_tdata), .S_AXIS_tvalid(S_AXIS_tvalid),
      .S_AXISCFG_tdata(S_AXISCFG_tdata), .S_AXISCFG_tvalid(S_AXISCFG_tvalid),
      .configuration_mode(configuration_mode), .configuration_axis(configuration_axis),
      .configuration_send(configuration_send),
      .dac_sclk(dac_sclk), .dac_sync_n(dac_sync_n), .dac_sdin(dac_sdin),
      .dac_ldac_n(dac_ldac_n), .ready(ready), .frame_count(frame_count)
   );

   always #5 a_clk = ~a_clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge a_clk);
      #1;
   endtask

   task automatic push_frame(input logic [NCH-1:0] mask, input logic [FRAME_BITS-1:0] d0,
                             input logic [FRAME_BITS-1:0] d1, input logic [FRAME_BITS-1:0] d2,
                             input logic [FRAME_BITS-1:0] d3);
      logic [NCH-1:0][FRAME_BITS-1:0] d;
      d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
      exp_mask_q.push_back(mask);
      exp_data_q.push_back(d);
   endtask

   task automatic drive_stream(input int ch, input logic [31:0] val);
      S_AXIS_tdata[ch*32 +: 32] = val;
      S_AXIS_tvalid[ch] = 1'b1;
      tick();
      S_AXIS_tvalid = '0;
   endtask

   task automatic wait_frames(input int target, input string tag);
      for (int i = 0; i < 2000 && frames_seen < target; i++) tick();
      chk(tag, frames_seen, target);
   endtask

   task automatic wait_bits(input int n, input string tag);
      for (int i = 0; i < 2000 && !(mon_active && mon_nbits >= n); i++) tick();
      chk(tag, mon_nbits, n);
   endtask

   task automatic wait_ready(input string tag);
      for (int i = 0; i < 2000 && !ready; i++) tick();
      chk(tag, ready, 1'b1);
   endtask

   task automatic frame_check();
      logic [NCH-1:0]                 em;
      logic [NCH-1:0][FRAME_BITS-1:0] ed;
      if (exp_mask_q.size() == 0) begin
         chk("frame_unexpected", exp_mask_q.size(), 1);
      end else begin
         em = exp_mask_q.pop_front();
         ed = exp_data_q.pop_front();
         chk($sformatf("frame%0d_mask", frames_seen), mon_mask, em);
         for (int k = 0; k < NCH; k++)
            chk($sformatf("frame%0d_ch%0d", frames_seen, k), mon_data[k], ed[k]);
         chk($sformatf("frame%0d_bits", frames_seen), mon_nbits, FRAME_BITS);
         chk($sformatf("frame%0d_sync_low_cycles", frames_seen), mon_low, FRAME_LOW);
         chk($sformatf("frame%0d_sync_shape", frames_seen), mon_shape_err, 1'b0);
      end
   endtask

   // Serial-line monitor, sampled on the falling clock edge
   initial begin
      forever begin
         @(negedge a_clk);
         if (!a_resetn) begin
            mon_active    = 1'b0;
            mon_prev_sclk = 1'b1;
         end else begin
            if (!mon_active && dac_sync_n != '1) begin
               mon_active    = 1'b1;
               mon_mask      = ~dac_sync_n;
               mon_nbits     = 0;
               mon_low       = 0;
               mon_data      = '0;
               mon_shape_err = 1'b0;
            end
            if (mon_active) begin
               if (dac_sync_n == '1) begin
                  frame_check();
                  mon_active = 1'b0;
                  frames_seen++;
               end else begin
                  mon_low++;
                  if (dac_sync_n != ~mon_mask) mon_shape_err = 1'b1;
                  if (mon_prev_sclk && !dac_sclk) begin
                     mon_nbits++;
                     for (int k = 0; k < NCH; k++)
                        mon_data[k] = {mon_data[k][FRAME_BITS-2:0], dac_sdin[k]};
                  end
               end
            end
            if (!dac_ldac_n) ldac_low_cnt++;
            mon_prev_sclk = dac_sclk;
         end
      end
   end

   // Directed sequence
   initial begin
      logic ready_all;
      logic sync_all;
      S_AXIS_tdata       = '0;
      S_AXIS_tvalid      = '0;
      S_AXISCFG_tdata    = 32'h0;
      S_AXISCFG_tvalid   = 1'b0;
      configuration_mode = 1'b0;
      configuration_axis = 3'd0;
      configuration_send = 1'b0;

      // Reset values
      #2 a_resetn = 1'b0;
      repeat (3) tick();
      chk("rst_sclk", dac_sclk, 1'b1);
      chk("rst_sync", dac_sync_n, 4'hF);
      chk("rst_sdin", dac_sdin, 4'h0);
      chk("rst_ready", ready, 1'b1);
      chk("rst_count", frame_count, 32'd0);
`ifdef AXIS_DAC_SERIAL_LDAC_EN
      chk("rst_ldac", dac_ldac_n, 1'b1);
`else
      chk("ldac_tied", dac_ldac_n, 1'b0);
`endif
      a_resetn = 1'b1;
      repeat (2) tick();

      // Stream frame on ch0, other channels carry code 0
      push_frame(4'hF, 24'h100010, 24'h100000, 24'h100000, 24'h100000);
      drive_stream(0, 32'h0001_0000);
      wait_frames(1, "f1_seen");
      wait_ready("f1_idle");
      chk("f1_count", frame_count, 32'd1);
`ifdef AXIS_DAC_SERIAL_LDAC_EN
      chk("f1_ldac_cycles", ldac_low_cnt, SCLK_DIV);
`else
      chk("f1_ldac_tied", dac_ldac_n, 1'b0);
`endif

      // Same value again: no frame, ready held
      drive_stream(0, 32'h0001_0000);
      ready_all = ready;
      for (int i = 0; i < 12; i++) begin
         tick();
         ready_all &= ready;
      end
      chk("resend_ready", ready_all, 1'b1);
      chk("resend_noframe", frames_seen, 1);

      // Config frame to channel 2
      configuration_mode = 1'b1;
      tick();
      S_AXISCFG_tdata    = 32'h0020_0012;
      S_AXISCFG_tvalid   = 1'b1;
      configuration_axis = 3'd2;
      push_frame(4'b0100, 24'h0, 24'h0, 24'h200012, 24'h0);
      configuration_send = 1'b1;
      tick();
      chk("cfg_ready_low", ready, 1'b0);
      wait_frames(2, "cfg_seen");
      chk("cfg_gap_ready", ready, 1'b0);
      repeat (SYNC_IDLE) tick();
      chk("cfg_ready_back", ready, 1'b1);
      chk("cfg_count", frame_count, 32'd2);
      configuration_send = 1'b0;
      tick();

      // Out-of-range channel
      configuration_axis = 3'd5;
      configuration_send = 1'b1;
      ready_all = 1'b1;
      sync_all  = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         ready_all &= ready;
         sync_all  &= (&dac_sync_n);
      end
      chk("axis5_sync", sync_all, 1'b1);
      chk("axis5_ready", ready_all, 1'b1);
      chk("axis5_noframe", frames_seen, 2);
      configuration_send = 1'b0;
      S_AXISCFG_tvalid   = 1'b0;
`ifdef AXIS_DAC_SERIAL_LDAC_EN
      chk("cfg_no_ldac", ldac_low_cnt, SCLK_DIV);
`endif

      // Stream update mid-frame, then a newer value overwrites it
      configuration_mode = 1'b0;
      tick();
      push_frame(4'hF, 24'h100010, 24'h100020, 24'h100000, 24'h100000);
      drive_stream(1, 32'h0002_0000);
      wait_bits(10, "mid_bit10");
      push_frame(4'hF, 24'h100010, 24'h100040, 24'h100000, 24'h100000);
      drive_stream(1, 32'h0003_0000);
      wait_bits(14, "mid_bit14");
      drive_stream(1, 32'h0004_0000);
      wait_frames(4, "two_frames_seen");
      wait_ready("two_frames_idle");
      chk("two_frames_count", frame_count, 32'd4);
`ifdef AXIS_DAC_SERIAL_LDAC_EN
      chk("two_frames_ldac", ldac_low_cnt, 3*SCLK_DIV);
`endif

      // Reset at bit 12 aborts the frame at once
      push_frame(4'hF, 24'h100050, 24'h100040, 24'h100000, 24'h100000);
      drive_stream(0, 32'h0005_0000);
      wait_bits(12, "abort_bit12");
      a_resetn = 1'b0;
      #1;
      chk("abort_sync", dac_sync_n, 4'hF);
      chk("abort_sclk", dac_sclk, 1'b1);
      chk("abort_sdin", dac_sdin, 4'h0);
      chk("abort_count", frame_count, 32'd0);
      exp_mask_q.delete();
      exp_data_q.delete();
      // Send held high across reset release must not count as an edge
      configuration_mode = 1'b1;
      configuration_axis = 3'd0;
      S_AXISCFG_tdata    = 32'h00AB_CDEF;
      S_AXISCFG_tvalid   = 1'b1;
      configuration_send = 1'b1;
      repeat (3) tick();
      a_resetn = 1'b1;
      ready_all = 1'b1;
      for (int i = 0; i < 30; i++) begin
         tick();
         ready_all &= ready;
      end
      chk("post_rst_ready", ready_all, 1'b1);
      chk("post_rst_noframe", frames_seen, 4);
      chk("post_rst_count", frame_count, 32'd0);
`ifdef AXIS_DAC_SERIAL_LDAC_EN
      chk("abort_no_ldac", ldac_low_cnt, 3*SCLK_DIV);
`else
      chk("post_rst_ldac_tied", dac_ldac_n, 1'b0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
